// File: rtl/ga_pkg.sv
// ga_pkg: shared types and constants for the GA evaluation blocks.
// Widths come from CHROM_WIDTH / FITNESS_WIDTH; defaults are supplied when the
// common defines have not been pulled in ahead of this file.
`ifndef CHROM_WIDTH
`define CHROM_WIDTH 16
`endif
`ifndef FITNESS_WIDTH
`define FITNESS_WIDTH 16
`endif

package ga_pkg;
    localparam int CHROM_W = `CHROM_WIDTH;
    localparam int FIT_W   = `FITNESS_WIDTH;

    typedef logic signed [CHROM_W-1:0] chrom_t;
    typedef logic signed [FIT_W-1:0]   fitness_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } collector_state_t;

    // Most-negative fitness: any real result beats it.
    localparam fitness_t FITNESS_MIN = {1'b1, {(FIT_W-1){1'b0}}};
endpackage

// File: rtl/fitness_collector_pair_compare.sv
// pair_compare: picks the winner of one fitness pair and decides whether it
// displaces the running best. Lane 1 wins ties inside the pair (lower index);
// the running best is only replaced on a strictly greater fitness so the
// earliest index keeps ties across pairs.
module pair_compare
    import ga_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic signed [FIT_W-1:0]   fit1,
    input  logic signed [FIT_W-1:0]   fit2,
    input  logic signed [CHROM_W-1:0] chrom1,
    input  logic signed [CHROM_W-1:0] chrom2,
    input  logic [IDX_W-1:0]          idx1,
    input  logic [IDX_W-1:0]          idx2,
    input  logic signed [FIT_W-1:0]   best_fit,
    input  logic signed [CHROM_W-1:0] best_chrom,
    input  logic [IDX_W-1:0]          best_idx,
    output logic signed [FIT_W-1:0]   nxt_fit,
    output logic signed [CHROM_W-1:0] nxt_chrom,
    output logic [IDX_W-1:0]          nxt_idx,
    output logic                      update
);
    fitness_t          win_fit_s;
    chrom_t            win_chrom_s;
    logic [IDX_W-1:0]  win_idx_s;

    // Pair winner, then compare against the running best
    always_comb begin
        win_fit_s   = fit1;
        win_chrom_s = chrom1;
        win_idx_s   = idx1;
        if (fit1 >= fit2) begin
            win_fit_s   = fit1;
            win_chrom_s = chrom1;
            win_idx_s   = idx1;
        end else begin
            win_fit_s   = fit2;
            win_chrom_s = chrom2;
            win_idx_s   = idx2;
        end

        update    = 1'b0;
        nxt_fit   = best_fit;
        nxt_chrom = best_chrom;
        nxt_idx   = best_idx;
        if (win_fit_s > best_fit) begin
            update    = 1'b1;
            nxt_fit   = win_fit_s;
            nxt_chrom = win_chrom_s;
            nxt_idx   = win_idx_s;
        end else begin
            update    = 1'b0;
            nxt_fit   = best_fit;
            nxt_chrom = best_chrom;
            nxt_idx   = best_idx;
        end
    end
endmodule

// File: rtl/fitness_collector.sv
// fitness_collector: runs one population evaluation through the dual-lane
// fitness function, fills the fitness register file and tracks the best
// chromosome. Optional macro FITNESS_SUM_EN adds the fitness_sum output.
module fitness_collector
    import ga_pkg::*;
#(
    parameter int POP_SIZE   = 16,
    parameter int FF_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(POP_SIZE/2)-1:0]     pair_idx,
    input  logic signed [CHROM_W-1:0]         pop_chrom1,
    input  logic signed [CHROM_W-1:0]         pop_chrom2,
    output logic signed [CHROM_W-1:0]         ff_chrom1,
    output logic signed [CHROM_W-1:0]         ff_chrom2,
    output logic                              ff_enable,
    input  logic signed [FIT_W-1:0]           ff_fitness1,
    input  logic signed [FIT_W-1:0]           ff_fitness2,
    input  logic [$clog2(POP_SIZE)-1:0]       fit_rd_addr,
    output logic signed [FIT_W-1:0]           fit_rd_data,
    output logic signed [CHROM_W-1:0]         best_chrom,
    output logic signed [FIT_W-1:0]           best_fitness,
    output logic [$clog2(POP_SIZE)-1:0]       best_idx
`ifdef FITNESS_SUM_EN
    ,
    output logic signed [FIT_W+$clog2(POP_SIZE)-1:0] fitness_sum
`endif
);
    localparam int IDX_W  = $clog2(POP_SIZE);
    localparam int PAIR_W = IDX_W - 1;
    localparam int PAIRS  = POP_SIZE / 2;

    collector_state_t  state_r, state_s;
    logic [PAIR_W-1:0] pair_idx_r;
    logic              accept_s, issue_s, last_s;

    chrom_t            ff_chrom1_r, ff_chrom2_r;
    logic              ff_enable_r;
    logic [PAIR_W-1:0] ff_idx_r;

    // Delay line runs parallel to the fitness pipeline; the operand registers
    // are recycled each cycle, so the chromosomes travel with the index.
    logic              dl_vld_r [FF_LATENCY];
    logic [PAIR_W-1:0] dl_idx_r [FF_LATENCY];
    chrom_t            dl_c1_r  [FF_LATENCY];
    chrom_t            dl_c2_r  [FF_LATENCY];

    logic              cap_s, pending_s;
    logic [PAIR_W-1:0] cap_idx_s;

    fitness_t          file_r [POP_SIZE];

    chrom_t            best_chrom_r, nxt_chrom_s;
    fitness_t          best_fit_r, nxt_fit_s;
    logic [IDX_W-1:0]  best_idx_r, nxt_idx_s;
    logic              upd_s;

    assign accept_s  = (state_r == IDLE) && start;
    assign issue_s   = (state_r == ISSUE);
    assign last_s    = (pair_idx_r == PAIR_W'(PAIRS - 1));
    assign cap_s     = dl_vld_r[FF_LATENCY-1];
    assign cap_idx_s = dl_idx_r[FF_LATENCY-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // A capture is still outstanding if any earlier stage holds a valid pair
    always_comb begin
        pending_s = ff_enable_r;
        for (int i = 0; i < FF_LATENCY - 1; i++) begin
            pending_s = pending_s | dl_vld_r[i];
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = ISSUE;
                else       state_s = IDLE;
            end
            ISSUE: begin
                if (last_s) state_s = DRAIN;
                else        state_s = ISSUE;
            end
            DRAIN: begin
                if (cap_s && !pending_s) state_s = DONE;
                else                     state_s = DRAIN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            ISSUE:   busy = 1'b1;
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Population pair address: restarts on acceptance, wraps after the last pair
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            pair_idx_r <= {PAIR_W{1'b0}};
        end else if (issue_s) begin
            pair_idx_r <= pair_idx_r + PAIR_W'(1);
        end
    end

    // Operand registers toward the fitness lanes; chromosomes hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_chrom1_r <= {CHROM_W{1'b0}};
            ff_chrom2_r <= {CHROM_W{1'b0}};
            ff_enable_r <= 1'b0;
            ff_idx_r    <= {PAIR_W{1'b0}};
        end else begin
            ff_enable_r <= issue_s;
            if (issue_s) begin
                ff_chrom1_r <= pop_chrom1;
                ff_chrom2_r <= pop_chrom2;
                ff_idx_r    <= pair_idx_r;
            end
        end
    end

    // Delay line shifting valid, pair index and chromosomes toward capture
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FF_LATENCY; i++) begin
                dl_vld_r[i] <= 1'b0;
                dl_idx_r[i] <= {PAIR_W{1'b0}};
                dl_c1_r[i]  <= {CHROM_W{1'b0}};
                dl_c2_r[i]  <= {CHROM_W{1'b0}};
            end
        end else begin
            dl_vld_r[0] <= ff_enable_r;
            dl_idx_r[0] <= ff_idx_r;
            dl_c1_r[0]  <= ff_chrom1_r;
            dl_c2_r[0]  <= ff_chrom2_r;
            for (int i = 1; i < FF_LATENCY; i++) begin
                dl_vld_r[i] <= dl_vld_r[i-1];
                dl_idx_r[i] <= dl_idx_r[i-1];
                dl_c1_r[i]  <= dl_c1_r[i-1];
                dl_c2_r[i]  <= dl_c2_r[i-1];
            end
        end
    end

    // Fitness file: both lanes of a captured pair land in adjacent slots
    always_ff @(posedge clk) begin
        if (cap_s && !rst) begin
            file_r[{cap_idx_s, 1'b0}] <= ff_fitness1;
            file_r[{cap_idx_s, 1'b1}] <= ff_fitness2;
        end
    end

    assign fit_rd_data = file_r[fit_rd_addr];

    pair_compare #(.IDX_W(IDX_W)) u_cmp (
        .fit1       (ff_fitness1),
        .fit2       (ff_fitness2),
        .chrom1     (dl_c1_r[FF_LATENCY-1]),
        .chrom2     (dl_c2_r[FF_LATENCY-1]),
        .idx1       ({cap_idx_s, 1'b0}),
        .idx2       ({cap_idx_s, 1'b1}),
        .best_fit   (best_fit_r),
        .best_chrom (best_chrom_r),
        .best_idx   (best_idx_r),
        .nxt_fit    (nxt_fit_s),
        .nxt_chrom  (nxt_chrom_s),
        .nxt_idx    (nxt_idx_s),
        .update     (upd_s)
    );

    // Running best: cleared per run, updated on a capture that beats it
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            best_fit_r   <= FITNESS_MIN;
            best_chrom_r <= {CHROM_W{1'b0}};
            best_idx_r   <= {IDX_W{1'b0}};
        end else if (cap_s && upd_s) begin
            best_fit_r   <= nxt_fit_s;
            best_chrom_r <= nxt_chrom_s;
            best_idx_r   <= nxt_idx_s;
        end
    end

`ifdef FITNESS_SUM_EN
    localparam int SUM_W = FIT_W + IDX_W;
    logic signed [SUM_W-1:0] sum_r;

    // Running total of every captured fitness, restarted with each run
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            sum_r <= {SUM_W{1'b0}};
        end else if (cap_s) begin
            sum_r <= sum_r + SUM_W'(ff_fitness1) + SUM_W'(ff_fitness2);
        end
    end

    assign fitness_sum = sum_r;
`endif

    assign pair_idx     = pair_idx_r;
    assign ff_chrom1    = ff_chrom1_r;
    assign ff_chrom2    = ff_chrom2_r;
    assign ff_enable    = ff_enable_r;
    assign best_chrom   = best_chrom_r;
    assign best_fitness = best_fit_r;
    assign best_idx     = best_idx_r;
endmodule
